// File: rtl/el2_pmp_chk_seq.sv
// Sequential PMP permission checker: scans entries a group per cycle,
// lowest index wins, answers over valid/ready, keeps a first-fault record.
module el2_pmp_chk_seq #(
  parameter int PMP_ENTRIES       = 16,
  parameter int ENTRIES_PER_CYCLE = 4
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic [8*PMP_ENTRIES-1:0]   pmp_cfg,
  input  logic [32*PMP_ENTRIES-1:0]  pmp_addr,
  input  logic                       pmp_cfg_chg,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [31:0]                req_addr,
  input  logic [1:0]                 req_type,
  input  logic                       req_priv_m,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_allow,
  output logic [5:0]                 rsp_entry,
  output logic                       fault_valid,
  output logic [31:0]                fault_addr,
  input  logic                       fault_clr
);

  localparam int IW = (PMP_ENTRIES > 1) ? $clog2(PMP_ENTRIES) : 1;
  localparam int LAST = PMP_ENTRIES - ENTRIES_PER_CYCLE;

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   addr_q, addr_d;
  logic [1:0]    type_q, type_d;
  logic          priv_q, priv_d;
  logic          allow_q, allow_d;
  logic [5:0]    entry_q, entry_d;
  logic          fv_q, fv_d;
  logic [31:0]   fa_q, fa_d;

  logic [31:0]                   wa;
  logic [32*PMP_ENTRIES+31:0]    lo_all;
  logic [PMP_ENTRIES-1:0]        match;
  logic [7:0]                    cfg_a [PMP_ENTRIES];

  assign wa     = {2'b00, addr_q[31:2]};
  assign lo_all = {pmp_addr, 32'h0};

  for (genvar i = 0; i < PMP_ENTRIES; i++) begin : g_ent
    logic [31:0] hi, lo, care;
    logic [1:0]  am;
    logic        tor, na4, napot;
    assign hi       = pmp_addr[32*i +: 32];
    assign lo       = lo_all[32*i +: 32];
    assign am       = pmp_cfg[8*i+3 +: 2];
    assign cfg_a[i] = pmp_cfg[8*i +: 8];
    // care masks out the trailing ones plus the first zero above them
    assign care  = ~(hi ^ (hi + 32'd1));
    assign tor   = (lo < hi) && (wa >= lo) && (wa < hi);
    assign na4   = (wa == hi);
    assign napot = ((wa ^ hi) & care) == 32'd0;
    assign match[i] = (am == 2'd1) ? tor :
                      (am == 2'd2) ? na4 :
                      (am == 2'd3) ? napot : 1'b0;
  end

  logic          hit;
  logic [IW-1:0] hit_idx;
  logic [IW-1:0] e;
  logic [7:0]    hsel;
  logic          perm;
  logic          allow_c;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    e       = '0;
    for (int j = ENTRIES_PER_CYCLE - 1; j >= 0; j--) begin
      e = idx_q + IW'(j);
      if (match[e]) begin
        hit     = 1'b1;
        hit_idx = e;
      end
    end
  end

  always_comb begin
    hsel = cfg_a[hit_idx];
    unique case (type_q)
      2'd0:    perm = hsel[0];
      2'd1:    perm = hsel[1];
      2'd2:    perm = hsel[2];
      default: perm = 1'b0;
    endcase
    if (!hit)         allow_c = priv_q;
    else if (hsel[7]) allow_c = perm;
    else              allow_c = priv_q | perm;
    if (type_q == 2'd3) allow_c = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    type_d  = type_q;
    priv_d  = priv_q;
    allow_d = allow_q;
    entry_d = entry_q;
    fv_d    = fv_q;
    fa_d    = fa_q;
    if (fault_clr) fv_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          type_d  = req_type;
          priv_d  = req_priv_m;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (pmp_cfg_chg) begin
          idx_d = '0;
        end else if (hit) begin
          entry_d = 6'(hit_idx);
          allow_d = allow_c;
          state_d = RESP;
        end else if (idx_q == IW'(LAST)) begin
          entry_d = 6'd63;
          allow_d = allow_c;
          state_d = RESP;
        end else begin
          idx_d = idx_q + IW'(ENTRIES_PER_CYCLE);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          // a denial on the handshake beats a simultaneous clear
          if (!allow_q && (!fv_q || fault_clr)) begin
            fv_d = 1'b1;
            fa_d = addr_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      type_q  <= '0;
      priv_q  <= 1'b0;
      allow_q <= 1'b0;
      entry_q <= 6'd63;
      fv_q    <= 1'b0;
      fa_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      type_q  <= type_d;
      priv_q  <= priv_d;
      allow_q <= allow_d;
      entry_q <= entry_d;
      fv_q    <= fv_d;
      fa_q    <= fa_d;
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_allow   = allow_q;
  assign rsp_entry   = entry_q;
  assign fault_valid = fv_q;
  assign fault_addr  = fa_q;

  logic unused_bits;
  assign unused_bits = ^{lo_all[32*PMP_ENTRIES +: 32],
                         addr_q[1:0], hsel[6:3]};

endmodule
